// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA/loader, the data RAM and the arbiter.
// The arbiter uses the slave modport; the surrounding system uses master.
interface dmem_port_arbiter_if #(
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          core_req;
  logic          core_we;
  logic [31:0]   core_addr;
  logic [31:0]   core_wdata;
  logic          core_stall;
  logic          core_rvalid;
  logic [31:0]   core_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [31:0]   dma_addr;
  logic [31:0]   dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [31:0]   dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic          addr_err;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  core_stall, core_rvalid, core_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  addr_err
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output core_stall, core_rvalid, core_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output addr_err
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port, 1-cycle-latency data RAM.
// Core has priority; a wait counter forces one DMA slot after MAX_WAIT denials.
module dmem_port_arbiter #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MaxWaitW = WW'(MAX_WAIT);
  localparam logic [29:0]   DepthW   = 30'(DEPTH);

  typedef enum logic [1:0] {RdNone, RdCore, RdDma} rd_owner_e;

  rd_owner_e     rd_owner_q, rd_owner_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          addr_err_q, addr_err_d;

  logic          force_dma, dma_win, core_win, any_win, out_of_range;
  logic          sel_we;
  logic [31:0]   sel_addr, sel_wdata;
  logic          unused_addr_lsb;

  // Grants are held off combinationally while reset is asserted.
  always_comb begin
    force_dma    = bus.dma_req && (wait_cnt_q == MaxWaitW);
    dma_win      = reset && bus.dma_req && (force_dma || !bus.core_req);
    core_win     = reset && bus.core_req && !dma_win;
    any_win      = dma_win || core_win;
    sel_we       = dma_win ? bus.dma_we    : bus.core_we;
    sel_addr     = dma_win ? bus.dma_addr  : bus.core_addr;
    sel_wdata    = dma_win ? bus.dma_wdata : bus.core_wdata;
    out_of_range = sel_addr[31:2] >= DepthW;
  end

  assign unused_addr_lsb = ^sel_addr[1:0];

  assign bus.core_stall = bus.core_req && dma_win;
  assign bus.dma_gnt    = dma_win;
  assign bus.mem_en     = any_win && !out_of_range;
  assign bus.mem_we     = any_win && !out_of_range && sel_we;
  assign bus.mem_addr   = sel_addr[AW+1:2];
  assign bus.mem_wdata  = sel_wdata;

  always_comb begin
    wait_cnt_d = '0;
    if (bus.dma_req && !dma_win) begin
      wait_cnt_d = (wait_cnt_q == MaxWaitW) ? wait_cnt_q : wait_cnt_q + WW'(1);
    end
  end

  assign addr_err_d = any_win && out_of_range;

  // Read-return FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner_q <= RdNone;
      wait_cnt_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rd_owner_q <= rd_owner_d;
      wait_cnt_q <= wait_cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Read-return FSM: next state follows whichever read was granted this cycle.
  always_comb begin
    rd_owner_d = RdNone;
    if (dma_win && !bus.dma_we) begin
      rd_owner_d = RdDma;
    end else if (core_win && !bus.core_we) begin
      rd_owner_d = RdCore;
    end
  end

  // Read-return FSM: outputs. A range error returns zero data.
  always_comb begin
    bus.core_rvalid = 1'b0;
    bus.core_rdata  = '0;
    bus.dma_rvalid  = 1'b0;
    bus.dma_rdata   = '0;
    unique case (rd_owner_q)
      RdCore: begin
        bus.core_rvalid = 1'b1;
        bus.core_rdata  = addr_err_q ? '0 : bus.mem_rdata;
      end
      RdDma: begin
        bus.dma_rvalid = 1'b1;
        bus.dma_rdata  = addr_err_q ? '0 : bus.mem_rdata;
      end
      default: ;
    endcase
  end

  assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 32-word, 1-cycle-latency RAM model.
// Inputs change at negedge; all outputs are sampled 1 ns later.
module tb_dmem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic        mem_load = 1'b1;
  logic [31:0] mem [32];
  logic [31:0] mem_rdata_q;

  dmem_port_arbiter_if #(.DEPTH(32)) bus ();

  dmem_port_arbiter #(
    .DEPTH    (32),
    .MAX_WAIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem_rdata_q;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem_rdata_q <= 32'h0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rdata_q <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cyc(input logic creq, input logic cwe, input logic [31:0] caddr,
                     input logic [31:0] cwd, input logic dreq, input logic dwe,
                     input logic [31:0] daddr, input logic [31:0] dwd);
    @(negedge clk);
    bus.core_req   = creq;
    bus.core_we    = cwe;
    bus.core_addr  = caddr;
    bus.core_wdata = cwd;
    bus.dma_req    = dreq;
    bus.dma_we     = dwe;
    bus.dma_addr   = daddr;
    bus.dma_wdata  = dwd;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".core_rvalid"}, 32'(bus.core_rvalid), 32'h0);
    chk({tag, ".core_rdata"},  bus.core_rdata,       32'h0);
    chk({tag, ".dma_rvalid"},  32'(bus.dma_rvalid),  32'h0);
    chk({tag, ".dma_rdata"},   bus.dma_rdata,        32'h0);
    chk({tag, ".addr_err"},    32'(bus.addr_err),    32'h0);
  endtask

  // Core reads word 0, DMA reads word 1, both held; DMA gets slot 4 only.
  task automatic contention(input string tag);
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
      chk($sformatf("%s.c%0d.dma_gnt", tag, c),    32'(bus.dma_gnt),    32'(c == 4));
      chk($sformatf("%s.c%0d.core_stall", tag, c), 32'(bus.core_stall), 32'(c == 4));
      chk($sformatf("%s.c%0d.mem_addr", tag, c),   32'(bus.mem_addr),   (c == 4) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 4) begin
        chk($sformatf("%s.c%0d.core_rdata", tag, c), bus.core_rdata, 32'hA000_0000);
      end
      if (c == 5) begin
        chk($sformatf("%s.c5.dma_rvalid", tag), 32'(bus.dma_rvalid), 32'h1);
        chk($sformatf("%s.c5.dma_rdata", tag),  bus.dma_rdata,       32'hA000_0001);
        chk($sformatf("%s.c5.core_rvalid", tag), 32'(bus.core_rvalid), 32'h0);
      end
    end
    idle();
    chk({tag, ".tail.core_rvalid"}, 32'(bus.core_rvalid), 32'h1);
    chk({tag, ".tail.dma_rvalid"},  32'(bus.dma_rvalid),  32'h0);
  endtask

  initial begin
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h0; bus.core_wdata = 32'h0;
    bus.dma_req  = 1'b1; bus.dma_we  = 1'b0; bus.dma_addr  = 32'h0; bus.dma_wdata  = 32'h0;
    #1;
    // Reset with both requesters active: everything off.
    chk_quiet("rst");
    chk("rst.mem_en",     32'(bus.mem_en),     32'h0);
    chk("rst.mem_we",     32'(bus.mem_we),     32'h0);
    chk("rst.dma_gnt",    32'(bus.dma_gnt),    32'h0);
    chk("rst.core_stall", 32'(bus.core_stall), 32'h0);
    repeat (2) @(posedge clk);
    mem_load = 1'b0;
    idle();
    reset = 1'b1;

    // Core write then read back.
    cyc(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wr.mem_en",     32'(bus.mem_en),     32'h1);
    chk("wr.mem_we",     32'(bus.mem_we),     32'h1);
    chk("wr.mem_addr",   32'(bus.mem_addr),   32'h4);
    chk("wr.mem_wdata",  bus.mem_wdata,       32'hDEAD_BEEF);
    chk("wr.core_stall", 32'(bus.core_stall), 32'h0);
    cyc(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd.mem_we",      32'(bus.mem_we),      32'h0);
    chk("rd.mem_addr",    32'(bus.mem_addr),    32'h4);
    chk("rd.core_rvalid", 32'(bus.core_rvalid), 32'h0);
    idle();
    chk("rd.ret.core_rvalid", 32'(bus.core_rvalid), 32'h1);
    chk("rd.ret.core_rdata",  bus.core_rdata,       32'hDEAD_BEEF);
    chk("rd.ret.dma_rvalid",  32'(bus.dma_rvalid),  32'h0);

    // DMA only.
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h08, 32'h0);
    chk("dma.gnt",      32'(bus.dma_gnt),  32'h1);
    chk("dma.mem_en",   32'(bus.mem_en),   32'h1);
    chk("dma.mem_addr", 32'(bus.mem_addr), 32'h2);
    idle();
    chk("dma.ret.dma_rvalid",  32'(bus.dma_rvalid),  32'h1);
    chk("dma.ret.dma_rdata",   bus.dma_rdata,        32'hA000_0002);
    chk("dma.ret.core_rvalid", 32'(bus.core_rvalid), 32'h0);
    chk("dma.ret.core_rdata",  bus.core_rdata,       32'h0);

    contention("cont");

    // Range boundary: last valid word, then first invalid one.
    cyc(1'b1, 1'b0, 32'h7C, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("oor.w31.mem_en",   32'(bus.mem_en),   32'h1);
    chk("oor.w31.mem_addr", 32'(bus.mem_addr), 32'd31);
    cyc(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("oor.w32.mem_en",     32'(bus.mem_en),     32'h0);
    chk("oor.w32.core_stall", 32'(bus.core_stall), 32'h0);
    chk("oor.w31.core_rdata", bus.core_rdata,      32'hA000_001F);
    chk("oor.w31.addr_err",   32'(bus.addr_err),   32'h0);
    idle();
    chk("oor.ret.addr_err",    32'(bus.addr_err),    32'h1);
    chk("oor.ret.core_rvalid", 32'(bus.core_rvalid), 32'h1);
    chk("oor.ret.core_rdata",  bus.core_rdata,       32'h0);
    idle();
    chk("oor.after.addr_err", 32'(bus.addr_err), 32'h0);

    // Reset in the cycle after a granted read.
    cyc(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    chk("mid.pre.core_rvalid", 32'(bus.core_rvalid), 32'h1);
    reset = 1'b0;
    #1;
    chk_quiet("mid.rst");
    chk("mid.rst.mem_en",  32'(bus.mem_en),  32'h0);
    chk("mid.rst.dma_gnt", 32'(bus.dma_gnt), 32'h0);
    chk("mid.rst.stall",   32'(bus.core_stall), 32'h0);
    repeat (2) @(posedge clk);
    idle();
    reset = 1'b1;
    #1;
    chk_quiet("mid.rel");
    contention("post");

    // Alternating owners on consecutive cycles.
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    chk("alt1.core_rvalid", 32'(bus.core_rvalid), 32'h1);
    chk("alt1.core_rdata",  bus.core_rdata,       32'hA000_0000);
    chk("alt1.dma_rvalid",  32'(bus.dma_rvalid),  32'h0);
    chk("alt1.dma_rdata",   bus.dma_rdata,        32'h0);
    cyc(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("alt2.dma_rvalid",  32'(bus.dma_rvalid),  32'h1);
    chk("alt2.dma_rdata",   bus.dma_rdata,        32'hA000_0001);
    chk("alt2.core_rvalid", 32'(bus.core_rvalid), 32'h0);
    chk("alt2.core_rdata",  bus.core_rdata,       32'h0);
    idle();
    chk("alt3.core_rdata", bus.core_rdata,      32'hDEAD_BEEF);
    chk("alt3.dma_rvalid", 32'(bus.dma_rvalid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
